// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: FIFO-buffered UART transmitter with run-time frame format (data bits, parity, stop bits)
module uart_tx_fifo_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata_i,
    input  logic                             s_axis_tvalid_i,
    output logic                             s_axis_tready_o,
    output logic                             txd_o,
    output logic                             busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o,
    input  logic [15:0]                      prescale_i,
    input  logic [3:0]                       data_bits_i,
    input  logic [1:0]                       parity_mode_i,
    input  logic                             two_stop_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  tready_q;
    logic                  push, pop, empty;

    state_t                state_q, state_d;
    logic [18:0]           cnt_q, cnt_d, per_q, per_d, per_new;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, word;
    logic [3:0]            bits_q, bits_d, nbits_new;
    logic                  par_en_q, par_en_d, par_q, par_d, par_x, par_new;
    logic                  stop2_q, stop2_d, txd_q, txd_d, load;

    assign push            = s_axis_tvalid_i && tready_q;
    assign pop             = load;
    assign empty           = (count_q == '0);
    assign count_d         = count_q + CW'(push) - CW'(pop);
    assign word            = mem_q[rd_ptr_q];
    assign s_axis_tready_o = tready_q;
    assign fifo_count_o    = count_q;
    assign txd_o           = txd_q;
    assign busy_o          = (state_q != IDLE);

    // Frame format sampled from the config inputs at the moment a word is popped
    assign per_new   = {(prescale_i == 16'd0) ? 16'd1 : prescale_i, 3'b000} - 19'd1;
    assign nbits_new = (data_bits_i < 4'd5) ? 4'd5 :
                       (data_bits_i > 4'(DATA_WIDTH)) ? 4'(DATA_WIDTH) : data_bits_i;
    assign par_new   = (parity_mode_i == 2'b11) ? 1'b1 :
                       (parity_mode_i == 2'b10) ? ~par_x : par_x;

    // Even parity over only the data bits that will actually be sent
    always_comb begin
        par_x = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (i < int'(nbits_new)) par_x ^= word[i];
    end

    // FIFO storage; contents need no reset because pointers/count define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_axis_tdata_i;
    end

    // FIFO pointers, occupancy and registered ready (low while in reset)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            tready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    // Serialiser state and latched frame registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            per_q    <= '0;
            sh_q     <= '0;
            bits_q   <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            sh_q     <= sh_d;
            bits_q   <= bits_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            txd_q    <= txd_d;
        end
    end

    // Next state: each state holds txd for one bit period, then advances; a pop starts a new frame
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        sh_d     = sh_q;
        bits_d   = bits_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        txd_d    = txd_q;
        load     = 1'b0;
        if (state_q != IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - 19'd1;
        end else begin
            cnt_d = per_q;
            case (state_q)
                IDLE:   load = !empty;
                START:  begin
                    state_d = DATA;
                    txd_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                end
                DATA:   begin
                    if (bits_q != 4'd0) begin
                        txd_d  = sh_q[0];
                        sh_d   = sh_q >> 1;
                        bits_d = bits_q - 4'd1;
                    end else begin
                        state_d = par_en_q ? PARITY : STOP;
                        txd_d   = par_en_q ? par_q : 1'b1;
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
                STOP:   begin
                    if (stop2_q) stop2_d = 1'b0;
                    else if (!empty) load = 1'b1;
                    else state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        if (load) begin
            state_d  = START;
            txd_d    = 1'b0;
            cnt_d    = per_new;
            per_d    = per_new;
            sh_d     = word;
            bits_d   = nbits_new - 4'd1;
            par_en_d = (parity_mode_i != 2'b00);
            par_d    = par_new;
            stop2_d  = two_stop_i;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: table-driven and randomized frame checks against a per-cycle waveform model
module tb_uart_tx_fifo_cfg;
    typedef struct {
        logic [7:0]  word;
        logic [15:0] p;
        logic [3:0]  db;
        logic [1:0]  par;
        logic        ts;
        int          len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready, txd, busy;
    logic [2:0]  fcount;
    logic [15:0] prescale = 16'd1;
    logic [3:0]  data_bits = 4'd8;
    logic [1:0]  parity = 2'd0;
    logic        two_stop = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    bit rec = 1'b0;
    logic [1:0] exp_q[$];
    logic [1:0] log_q[$];
    vec_t tab[6];

    uart_tx_fifo_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid), .s_axis_tready_o(tready),
        .txd_o(txd), .busy_o(busy), .fifo_count_o(fcount),
        .prescale_i(prescale), .data_bits_i(data_bits), .parity_mode_i(parity), .two_stop_i(two_stop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rec) log_q.push_back({busy, txd});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Expected {busy,txd} per cycle for one frame, built from the frame rules
    task automatic add_frame(input logic [7:0] w, input int p, input int db, input int par,
                             input bit ts, output int len);
        bit bits[$];
        int per, n;
        bit x;
        per = 8 * ((p == 0) ? 1 : p);
        n = (db < 5) ? 5 : (db > 8) ? 8 : db;
        x = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(w[i]);
            x ^= w[i];
        end
        if (par == 1) bits.push_back(x);
        if (par == 2) bits.push_back(!x);
        if (par == 3) bits.push_back(1'b1);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        foreach (bits[i]) repeat (per) exp_q.push_back({1'b1, bits[i]});
        len = bits.size() * per;
    endtask

    task automatic compare_log(input string name, input int busy_len);
        int n, b;
        n = 0;
        b = 0;
        while (log_q.size() < exp_q.size() && n < exp_q.size() + 20) begin
            @(negedge clk);
            n++;
        end
        #1 rec = 1'b0;
        if (log_q.size() < exp_q.size()) begin
            chk({name, "_timeout"}, log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (log_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d: busy,txd got %b expected %b", name, i, log_q[i], exp_q[i]);
                end
                if (log_q[i][1]) b++;
            end
            chk({name, "_busy_len"}, b, busy_len);
        end
    endtask

    task automatic start_rec();
        exp_q.delete();
        log_q.delete();
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        rec = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int mlen;
        @(posedge clk); #1;
        prescale = v.p;
        data_bits = v.db;
        parity = v.par;
        two_stop = v.ts;
        tdata = v.word;
        tvalid = 1'b1;
        start_rec();
        add_frame(v.word, v.p, v.db, v.par, v.ts, mlen);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        @(posedge clk); #1;
        tvalid = 1'b0;
        compare_log(name, (v.len != 0) ? v.len : mlen);
    endtask

    initial begin
        int mlen, idx, flag;
        bit hs;
        vec_t v;
        logic [7:0] w[6];
        tab[0] = '{8'hA5, 16'd1, 4'd8,  2'd0, 1'b0, 80};
        tab[1] = '{8'h41, 16'd2, 4'd7,  2'd1, 1'b0, 160};
        tab[2] = '{8'h00, 16'd1, 4'd8,  2'd2, 1'b1, 96};
        tab[3] = '{8'h1F, 16'd0, 4'd2,  2'd3, 1'b0, 64};
        tab[4] = '{8'h3C, 16'd1, 4'd15, 2'd2, 1'b1, 96};
        tab[5] = '{8'h96, 16'd3, 4'd6,  2'd1, 1'b1, 240};

        #12;
        chk("reset_txd", txd, 1);
        chk("reset_tready", tready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", fcount, 0);
        #16 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_tready", tready, 1);

        foreach (tab[i]) run_vec(tab[i], $sformatf("tab%0d", i));

        for (int r = 0; r < 12; r++) begin
            v.word = 8'($urandom);
            v.p = 16'($urandom_range(0, 2));
            v.db = 4'($urandom_range(0, 15));
            v.par = 2'($urandom_range(0, 3));
            v.ts = 1'($urandom_range(0, 1));
            v.len = 0;
            run_vec(v, $sformatf("rand%0d", r));
        end

        // Six words with tvalid held: FIFO fills, frames run back-to-back
        for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
        @(posedge clk); #1;
        prescale = 16'd1; data_bits = 4'd8; parity = 2'd0; two_stop = 1'b0;
        tdata = w[0];
        tvalid = 1'b1;
        start_rec();
        for (int i = 0; i < 6; i++) add_frame(w[i], 1, 8, 0, 1'b0, mlen);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        idx = 0;
        for (int k = 0; k < 83; k++) begin
            hs = tready;
            @(posedge clk); #1;
            if (hs && tvalid) idx++;
            if (k == 4) begin
                chk("full_accepted", idx, 5);
                chk("full_count", fcount, 4);
                chk("full_tready", tready, 0);
            end
            if (k == 40) chk("full_hold_count", fcount, 4);
            if (k == 81) begin
                chk("pop_count", fcount, 3);
                chk("pop_tready", tready, 1);
            end
            if (k == 82) begin
                chk("refill_count", fcount, 4);
                chk("refill_accepted", idx, 6);
            end
            if (idx < 6) tdata = w[idx];
            else tvalid = 1'b0;
        end
        compare_log("b2b", 480);

        // Config change mid-frame affects only the following frame
        @(posedge clk); #1;
        tdata = 8'hC3;
        tvalid = 1'b1;
        start_rec();
        add_frame(8'hC3, 1, 8, 0, 1'b0, mlen);
        add_frame(8'h5A, 1, 5, 0, 1'b0, mlen);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        @(posedge clk); #1;
        tdata = 8'h5A;
        @(posedge clk); #1;
        tvalid = 1'b0;
        data_bits = 4'd5;
        compare_log("cfg_change", 136);

        // Asynchronous reset in the middle of a data bit
        @(posedge clk); #1;
        data_bits = 4'd8;
        tdata = 8'h00;
        tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1 tvalid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("pre_reset_txd", txd, 0);
        chk("pre_reset_count", fcount, 2);
        chk("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_txd", txd, 1);
        chk("async_busy", busy, 0);
        chk("async_count", fcount, 0);
        chk("async_tready", tready, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rerelease_tready", tready, 1);
        chk("rerelease_count", fcount, 0);
        flag = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) flag = 1;
        end
        chk("post_reset_idle", flag, 0);

        run_vec(tab[0], "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
